// File: rtl/i4004_bus_master_if.sv
// 4004-style multiplexed nibble bus shared by the
// bus master and its ROM/RAM responders.
interface i4004_bus_master_if;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_oe;
  logic       sync;
  logic       cm_rom;
  logic       cm_ram;

  modport master (
    input  data_in,
    output data_out,
    output data_oe,
    output sync,
    output cm_rom,
    output cm_ram
  );

  modport slave (
    output data_in,
    input  data_out,
    input  data_oe,
    input  sync,
    input  cm_rom,
    input  cm_ram
  );
endinterface

// File: rtl/i4004_bus_master.sv
// 4004-style bus master: eight-phase instruction ring
// sequencing PC out, opcode fetch, SRC and I/O traffic.
module i4004_bus_master #(
  parameter logic [11:0] PC_RESET = 12'h000
) (
  input  logic                       cp2,
  input  logic                       reset,
  i4004_bus_master_if.master         bus,
  input  logic                       jmp_valid,
  input  logic [11:0]                jmp_addr,
  input  logic [7:0]                 src_pair,
  input  logic [3:0]                 wr_data,
  output logic [3:0]                 instr_opr,
  output logic [3:0]                 instr_opa,
  output logic                       instr_valid,
  output logic [3:0]                 rd_data,
  output logic                       rd_valid,
  output logic [11:0]                pc
);

  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, E1, E2, E3
  } state_t;

  state_t     state, state_nx;
  logic       active;
  logic [7:0] src_q;
  logic [3:0] wr_q;
  logic       is_src, is_wr, is_rd;

  // active stays low while reset is held, so outputs are quiet
  // and the ring resumes at A1 in the cycle after release
  always_ff @(posedge cp2) begin
    if (!reset) begin
      state  <= A1;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nx = A1;
    if (active) begin
      unique case (state)
        A1: state_nx = A2;
        A2: state_nx = A3;
        A3: state_nx = M1;
        M1: state_nx = M2;
        M2: state_nx = E1;
        E1: state_nx = E2;
        E2: state_nx = E3;
        E3: state_nx = A1;
      endcase
    end
  end

  assign is_src = (instr_opr == 4'h2) && instr_opa[0];
  assign is_wr  = (instr_opr == 4'hE) && !instr_opa[3];
  assign is_rd  = (instr_opr == 4'hE) && instr_opa[3];

  always_ff @(posedge cp2) begin
    if (!reset) begin
      pc        <= PC_RESET;
      instr_opr <= 4'h0;
      instr_opa <= 4'h0;
      rd_data   <= 4'h0;
      src_q     <= 8'h00;
      wr_q      <= 4'h0;
    end else if (active) begin
      if (state == M1)
        instr_opr <= bus.data_in;
      if (state == M2)
        instr_opa <= bus.data_in;
      if (state == E1) begin
        src_q <= src_pair;
        wr_q  <= wr_data;
        pc    <= jmp_valid ? jmp_addr : pc + 12'd1;
      end
      if (state == E2 && is_rd)
        rd_data <= bus.data_in;
    end
  end

  always_comb begin
    bus.data_out = 4'h0;
    bus.data_oe  = 1'b0;
    bus.sync     = 1'b0;
    bus.cm_rom   = 1'b0;
    bus.cm_ram   = 1'b0;
    instr_valid  = 1'b0;
    rd_valid     = 1'b0;
    if (active) begin
      unique case (state)
        A1: begin
          bus.data_oe  = 1'b1;
          bus.data_out = pc[3:0];
        end
        A2: begin
          bus.data_oe  = 1'b1;
          bus.data_out = pc[7:4];
        end
        A3: begin
          bus.data_oe  = 1'b1;
          bus.data_out = pc[11:8];
        end
        M1: ;
        M2: begin
          bus.cm_rom = 1'b1;
          bus.cm_ram = 1'b1;
        end
        E1: instr_valid = 1'b1;
        E2: begin
          if (is_src) begin
            bus.data_oe  = 1'b1;
            bus.data_out = src_q[7:4];
            bus.cm_rom   = 1'b1;
            bus.cm_ram   = 1'b1;
          end else if (is_wr) begin
            bus.data_oe  = 1'b1;
            bus.data_out = wr_q;
          end
        end
        E3: begin
          bus.sync = 1'b1;
          if (is_src) begin
            bus.data_oe  = 1'b1;
            bus.data_out = src_q[3:0];
          end
          rd_valid = is_rd;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i4004_bus_master.sv
// Directed + randomized instruction-level bench for
// i4004_bus_master against a per-instruction model.
module tb_i4004_bus_master;

  localparam logic [11:0] PCR = 12'h123;

  logic        cp2 = 1'b0;
  logic        reset = 1'b0;
  logic        jmp_valid = 1'b0;
  logic [11:0] jmp_addr = 12'h000;
  logic [7:0]  src_pair = 8'h00;
  logic [3:0]  wr_data = 4'h0;
  logic [3:0]  instr_opr, instr_opa, rd_data;
  logic        instr_valid, rd_valid;
  logic [11:0] pc;

  int errors = 0;
  int checks = 0;

  logic [11:0] mpc;
  logic [3:0]  mrd;

  i4004_bus_master_if bus ();

  i4004_bus_master #(.PC_RESET(PCR)) dut (
    .cp2         (cp2),
    .reset       (reset),
    .bus         (bus),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .src_pair    (src_pair),
    .wr_data     (wr_data),
    .instr_opr   (instr_opr),
    .instr_opa   (instr_opa),
    .instr_valid (instr_valid),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .pc          (pc)
  );

  always #5 cp2 = ~cp2;

  task automatic step;
    @(posedge cp2);
    #1;
  endtask

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(string ph, logic oe, logic [3:0] dout,
                         logic sy, logic cm, logic iv, logic rv);
    chk({ph, ".oe"},   {11'd0, bus.data_oe},  {11'd0, oe});
    chk({ph, ".out"},  {8'd0, bus.data_out},  {8'd0, dout});
    chk({ph, ".sync"}, {11'd0, bus.sync},     {11'd0, sy});
    chk({ph, ".rom"},  {11'd0, bus.cm_rom},   {11'd0, cm});
    chk({ph, ".ram"},  {11'd0, bus.cm_ram},   {11'd0, cm});
    chk({ph, ".iv"},   {11'd0, instr_valid},  {11'd0, iv});
    chk({ph, ".rv"},   {11'd0, rd_valid},     {11'd0, rv});
  endtask

  // 0 other, 1 SRC, 2 IOR write, 3 IOR read
  function automatic int cls(logic [3:0] o, logic [3:0] a);
    if (o == 4'h2 && a[0]) return 1;
    if (o == 4'hE) return a[3] ? 3 : 2;
    return 0;
  endfunction

  task automatic run_instr(logic [3:0] opr, logic [3:0] opa,
                           logic [7:0] src, logic [3:0] wr,
                           logic [3:0] rdv, logic jv,
                           logic [11:0] ja, logic jmp_a2,
                           logic abort_e2);
    int c;
    c = cls(opr, opa);
    chk_bus("A1", 1'b1, mpc[3:0], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("A1.pc", pc, mpc);
    step;
    chk_bus("A2", 1'b1, mpc[7:4], 1'b0, 1'b0, 1'b0, 1'b0);
    if (jmp_a2) begin
      jmp_valid = 1'b1;
      jmp_addr  = 12'($urandom);
    end
    step;
    jmp_valid = 1'b0;
    chk_bus("A3", 1'b1, mpc[11:8], 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    chk_bus("M1", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.data_in = opr;
    step;
    chk_bus("M2", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.data_in = opa;
    step;
    bus.data_in = 4'($urandom);
    chk_bus("E1", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("E1.opr", {8'd0, instr_opr}, {8'd0, opr});
    chk("E1.opa", {8'd0, instr_opa}, {8'd0, opa});
    src_pair  = src;
    wr_data   = wr;
    jmp_valid = jv;
    jmp_addr  = ja;
    step;
    mpc = jv ? ja : mpc + 12'd1;
    jmp_valid = 1'b0;
    src_pair  = 8'($urandom);
    wr_data   = 4'($urandom);
    chk("E2.pc", pc, mpc);
    case (c)
      1: chk_bus("E2", 1'b1, src[7:4], 1'b0, 1'b1, 1'b0, 1'b0);
      2: chk_bus("E2", 1'b1, wr, 1'b0, 1'b0, 1'b0, 1'b0);
      default: chk_bus("E2", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endcase
    bus.data_in = rdv;
    if (abort_e2) begin
      reset = 1'b0;
      step;
      chk_bus("ABT", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ABT.rd", {8'd0, rd_data}, 12'h000);
      chk("ABT.pc", pc, PCR);
      step;
      chk("ABT2.rv", {11'd0, rd_valid}, 12'h000);
      reset = 1'b1;
      step;
      mpc = PCR;
      mrd = 4'h0;
      return;
    end
    step;
    if (c == 3) mrd = rdv;
    case (c)
      1: chk_bus("E3", 1'b1, src[3:0], 1'b1, 1'b0, 1'b0, 1'b0);
      3: chk_bus("E3", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      default: chk_bus("E3", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endcase
    chk("E3.rd", {8'd0, rd_data}, {8'd0, mrd});
    step;
  endtask

  initial begin
    logic [3:0] o;
    bus.data_in = 4'h0;
    reset = 1'b0;
    step;
    step;
    chk_bus("RST", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("RST.pc", pc, PCR);
    chk("RST.opr", {8'd0, instr_opr}, 12'h000);
    chk("RST.opa", {8'd0, instr_opa}, 12'h000);
    chk("RST.rd", {8'd0, rd_data}, 12'h000);
    reset = 1'b1;
    step;
    mpc = PCR;
    mrd = 4'h0;

    run_instr(4'hD, 4'h5, 8'h00, 4'h0, 4'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    run_instr(4'h2, 4'h1, 8'hA7, 4'h0, 4'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    run_instr(4'hE, 4'h0, 8'h00, 4'h9, 4'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    run_instr(4'hE, 4'hA, 8'h00, 4'h0, 4'h6, 1'b0, 12'h0, 1'b0, 1'b0);
    run_instr(4'h1, 4'h3, 8'h00, 4'h0, 4'h0, 1'b1, 12'hFFF, 1'b0, 1'b0);
    run_instr(4'h4, 4'h4, 8'h00, 4'h0, 4'h0, 1'b0, 12'h0, 1'b0, 1'b0);
    run_instr(4'h1, 4'h3, 8'h00, 4'h0, 4'h0, 1'b1, 12'h3C0, 1'b0, 1'b0);
    run_instr(4'h2, 4'h0, 8'h5C, 4'h0, 4'h0, 1'b0, 12'h0, 1'b1, 1'b0);
    run_instr(4'hE, 4'hF, 8'h00, 4'h0, 4'hB, 1'b0, 12'h0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: o = 4'h2;
        1: o = 4'hE;
        default: o = 4'($urandom);
      endcase
      run_instr(o, 4'($urandom), 8'($urandom), 4'($urandom),
                4'($urandom), ($urandom_range(0, 3) == 0),
                12'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    run_instr(4'hE, 4'hA, 8'h00, 4'h0, 4'h6, 1'b0, 12'h0, 1'b0, 1'b1);
    run_instr(4'hE, 4'h8, 8'h00, 4'h0, 4'h3, 1'b0, 12'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
